// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory bus (cbus) between the core's data and
// instruction ports. Data wins by default; an instruction request that has
// lost MaxWait consecutive arbitrations wins the next one. The granted request
// is latched and held on cbus until its final beat completes.
module mem_bus_arbiter #(
  parameter int unsigned AddrW   = 64,
  parameter int unsigned DataW   = 64,
  parameter int unsigned MaxWait = 4
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  // Data port
  input  logic                 d_valid_i,
  input  logic                 d_is_write_i,
  input  logic [AddrW-1:0]     d_addr_i,
  input  logic [DataW/8-1:0]   d_strobe_i,
  input  logic [DataW-1:0]     d_wdata_i,
  input  logic [3:0]           d_len_i,
  output logic                 d_ready_o,
  output logic                 d_last_o,
  output logic [DataW-1:0]     d_rdata_o,
  // Instruction port
  input  logic                 i_valid_i,
  input  logic [AddrW-1:0]     i_addr_i,
  input  logic [3:0]           i_len_i,
  output logic                 i_ready_o,
  output logic                 i_last_o,
  output logic [DataW-1:0]     i_rdata_o,
  // Shared cbus
  output logic                 c_valid_o,
  output logic                 c_is_write_o,
  output logic [AddrW-1:0]     c_addr_o,
  output logic [DataW/8-1:0]   c_strobe_o,
  output logic [DataW-1:0]     c_wdata_o,
  output logic [3:0]           c_len_o,
  input  logic                 c_ready_i,
  input  logic                 c_last_i,
  input  logic [DataW-1:0]     c_rdata_i
);

  localparam int unsigned StrbW = DataW / 8;
  localparam logic [3:0] MaxWaitC = 4'(MaxWait);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e             state_q, state_d;
  logic               grant_i_q, grant_i_d;  // 1: instruction port owns the bus
  logic [3:0]         wait_cnt_q, wait_cnt_d;
  logic               c_is_write_q, c_is_write_d;
  logic [AddrW-1:0]   c_addr_q, c_addr_d;
  logic [StrbW-1:0]   c_strobe_q, c_strobe_d;
  logic [DataW-1:0]   c_wdata_q, c_wdata_d;
  logic [3:0]         c_len_q, c_len_d;

  logic latch_en;
  logic pick_i;

  assign latch_en = (state_q == StIdle) && (d_valid_i || i_valid_i);
  assign pick_i   = i_valid_i && (!d_valid_i || (wait_cnt_q == MaxWaitC));

  // State register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: any request in idle starts a transaction; final beat ends it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (d_valid_i || i_valid_i) state_d = StBusy;
      StBusy:  if (c_ready_i && c_last_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Grant decision, starvation counter and request latch.
  always_comb begin
    grant_i_d    = grant_i_q;
    wait_cnt_d   = wait_cnt_q;
    c_is_write_d = c_is_write_q;
    c_addr_d     = c_addr_q;
    c_strobe_d   = c_strobe_q;
    c_wdata_d    = c_wdata_q;
    c_len_d      = c_len_q;
    if (latch_en) begin
      grant_i_d = pick_i;
      if (pick_i) begin
        wait_cnt_d   = '0;
        c_is_write_d = 1'b0;
        c_addr_d     = i_addr_i;
        c_strobe_d   = '0;
        c_wdata_d    = '0;
        c_len_d      = i_len_i;
      end else begin
        if (i_valid_i && (wait_cnt_q != MaxWaitC)) wait_cnt_d = wait_cnt_q + 4'd1;
        c_is_write_d = d_is_write_i;
        c_addr_d     = d_addr_i;
        c_strobe_d   = d_strobe_i;
        c_wdata_d    = d_wdata_i;
        // Writes are single-beat regardless of d_len.
        c_len_d      = d_is_write_i ? 4'd0 : d_len_i;
      end
    end
  end

  // Request register; only ever updated from idle, so cbus is stable in busy.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      grant_i_q    <= 1'b0;
      wait_cnt_q   <= '0;
      c_is_write_q <= 1'b0;
      c_addr_q     <= '0;
      c_strobe_q   <= '0;
      c_wdata_q    <= '0;
      c_len_q      <= '0;
    end else begin
      grant_i_q    <= grant_i_d;
      wait_cnt_q   <= wait_cnt_d;
      c_is_write_q <= c_is_write_d;
      c_addr_q     <= c_addr_d;
      c_strobe_q   <= c_strobe_d;
      c_wdata_q    <= c_wdata_d;
      c_len_q      <= c_len_d;
    end
  end

  // Outputs: cbus from the latch; beat responses routed to the owner only.
  always_comb begin
    c_valid_o    = (state_q == StBusy);
    c_is_write_o = c_is_write_q;
    c_addr_o     = c_addr_q;
    c_strobe_o   = c_strobe_q;
    c_wdata_o    = c_wdata_q;
    c_len_o      = c_len_q;
    d_ready_o    = 1'b0;
    d_last_o     = 1'b0;
    d_rdata_o    = '0;
    i_ready_o    = 1'b0;
    i_last_o     = 1'b0;
    i_rdata_o    = '0;
    if (state_q == StBusy) begin
      if (grant_i_q) begin
        i_ready_o = c_ready_i;
        i_last_o  = c_ready_i && c_last_i;
        i_rdata_o = c_rdata_i;
      end else begin
        d_ready_o = c_ready_i;
        d_last_o  = c_ready_i && c_last_i;
        d_rdata_o = c_rdata_i;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model of the arbitration rules.
module tb_mem_bus_arbiter;

  localparam int unsigned AddrW   = 64;
  localparam int unsigned DataW   = 64;
  localparam int unsigned MaxWait = 4;
  localparam int unsigned StrbW   = DataW / 8;

  logic clk = 1'b0;
  logic reset;
  logic d_valid, d_is_write, d_ready, d_last;
  logic [AddrW-1:0] d_addr;
  logic [StrbW-1:0] d_strobe;
  logic [DataW-1:0] d_wdata, d_rdata;
  logic [3:0] d_len;
  logic i_valid, i_ready, i_last;
  logic [AddrW-1:0] i_addr;
  logic [3:0] i_len;
  logic [DataW-1:0] i_rdata;
  logic c_valid, c_is_write, c_ready, c_last;
  logic [AddrW-1:0] c_addr;
  logic [StrbW-1:0] c_strobe;
  logic [DataW-1:0] c_wdata, c_rdata;
  logic [3:0] c_len;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.AddrW(AddrW), .DataW(DataW), .MaxWait(MaxWait)) dut (
    .clk_i(clk), .reset_i(reset),
    .d_valid_i(d_valid), .d_is_write_i(d_is_write), .d_addr_i(d_addr),
    .d_strobe_i(d_strobe), .d_wdata_i(d_wdata), .d_len_i(d_len),
    .d_ready_o(d_ready), .d_last_o(d_last), .d_rdata_o(d_rdata),
    .i_valid_i(i_valid), .i_addr_i(i_addr), .i_len_i(i_len),
    .i_ready_o(i_ready), .i_last_o(i_last), .i_rdata_o(i_rdata),
    .c_valid_o(c_valid), .c_is_write_o(c_is_write), .c_addr_o(c_addr),
    .c_strobe_o(c_strobe), .c_wdata_o(c_wdata), .c_len_o(c_len),
    .c_ready_i(c_ready), .c_last_i(c_last), .c_rdata_i(c_rdata)
  );

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    d_valid = 0; d_is_write = 0; d_addr = '0; d_strobe = '0; d_wdata = '0; d_len = '0;
    i_valid = 0; i_addr = '0; i_len = '0;
    c_ready = 0; c_last = 0; c_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    // Junk on every input while reset is held: nothing may be latched.
    reset = 1;
    d_valid = 1; d_is_write = 1; d_addr = rand64(); d_strobe = 8'hFF; d_wdata = rand64();
    d_len = 4'hF; i_valid = 1; i_addr = rand64(); i_len = 4'h7;
    c_ready = 1; c_last = 1; c_rdata = rand64();
    tick();
    tick();
    reset = 0;
    d_valid = 0; i_valid = 0;
    #2;
    n_total++;
    if (c_valid !== 1'b0) $display("FAIL reset_c_valid: got %b want 0", c_valid);
    else n_pass++;
    n_total++;
    if ({c_is_write, c_len, c_strobe} !== '0)
      $display("FAIL reset_c_ctrl: got %h want 0", {c_is_write, c_len, c_strobe});
    else n_pass++;
    n_total++;
    if ({c_addr, c_wdata} !== '0) $display("FAIL reset_c_data: got %h want 0", {c_addr, c_wdata});
    else n_pass++;
    // cbus responses are ignored while idle.
    n_total++;
    if ({d_ready, d_last, i_ready, i_last, d_rdata, i_rdata} !== '0)
      $display("FAIL reset_port_outs: got %h want 0",
               {d_ready, d_last, i_ready, i_last, d_rdata, i_rdata});
    else n_pass++;
    tick();
    #2;
    n_total++;
    if (c_valid !== 1'b0) $display("FAIL reset_stays_idle: got %b want 0", c_valid);
    else n_pass++;
  endtask

  task automatic test_single_read();
    do_reset();
    d_valid = 1; d_is_write = 0; d_addr = 64'h8000_0000; d_len = 0;
    d_strobe = 8'h0F; d_wdata = rand64();
    #2;
    n_total++;
    if (c_valid !== 1'b0) $display("FAIL sr_cycle0_c_valid: got %b want 0", c_valid);
    else n_pass++;
    tick();
    #2;
    n_total++;
    if ({c_valid, c_is_write, c_len} !== {1'b1, 1'b0, 4'd0})
      $display("FAIL sr_cycle1_ctrl: got %b want 1_0_0000", {c_valid, c_is_write, c_len});
    else n_pass++;
    n_total++;
    if (c_addr !== 64'h8000_0000) $display("FAIL sr_cycle1_addr: got %h want 80000000", c_addr);
    else n_pass++;
    tick();
    #2;
    n_total++;
    if ({d_ready, d_last} !== 2'b00) $display("FAIL sr_cycle2_ready: got %b want 00", {d_ready, d_last});
    else n_pass++;
    tick();
    c_ready = 1; c_last = 1; c_rdata = 64'h1122_3344_5566_7788;
    #2;
    n_total++;
    if ({d_ready, d_last, i_ready, i_last} !== 4'b1100)
      $display("FAIL sr_cycle3_hs: got %b want 1100", {d_ready, d_last, i_ready, i_last});
    else n_pass++;
    n_total++;
    if (d_rdata !== 64'h1122_3344_5566_7788)
      $display("FAIL sr_cycle3_rdata: got %h want 1122334455667788", d_rdata);
    else n_pass++;
    tick();
    d_valid = 0; c_ready = 0; c_last = 0;
    #2;
    n_total++;
    if (c_valid !== 1'b0) $display("FAIL sr_cycle4_c_valid: got %b want 0", c_valid);
    else n_pass++;
  endtask

  task automatic test_priority();
    logic [63:0] da, ia, rd;
    da = rand64(); ia = rand64(); rd = rand64();
    do_reset();
    d_valid = 1; d_is_write = 1; d_addr = da; d_len = 4'd9; d_strobe = 8'hA5; d_wdata = rand64();
    i_valid = 1; i_addr = ia; i_len = 0;
    tick();
    c_ready = 1; c_last = 1;
    #2;
    n_total++;
    if ({c_addr, c_is_write, c_len} !== {da, 1'b1, 4'd0})
      $display("FAIL prio_d_first: got %h want %h", {c_addr, c_is_write, c_len}, {da, 1'b1, 4'd0});
    else n_pass++;
    n_total++;
    if ({d_ready, i_ready} !== 2'b10) $display("FAIL prio_i_blocked: got %b want 10", {d_ready, i_ready});
    else n_pass++;
    tick();
    d_valid = 0; c_ready = 0; c_last = 0;
    #2;
    n_total++;
    if (c_valid !== 1'b0) $display("FAIL prio_gap: got %b want 0", c_valid);
    else n_pass++;
    tick();
    #2;
    n_total++;
    if ({c_valid, c_addr, c_is_write, c_strobe, c_wdata} !== {1'b1, ia, 1'b0, 8'h00, 64'h0})
      $display("FAIL prio_i_second: got %h want %h", {c_valid, c_addr, c_is_write, c_strobe, c_wdata},
               {1'b1, ia, 1'b0, 8'h00, 64'h0});
    else n_pass++;
    tick();
    c_ready = 1; c_last = 1; c_rdata = rd;
    #2;
    n_total++;
    if ({i_ready, i_last, d_ready, i_rdata} !== {3'b110, rd})
      $display("FAIL prio_i_beat: got %h want %h", {i_ready, i_last, d_ready, i_rdata}, {3'b110, rd});
    else n_pass++;
    tick();
    i_valid = 0; c_ready = 0; c_last = 0;
  endtask

  task automatic test_starvation();
    logic [63:0] ia;
    logic exp_i;
    ia = rand64();
    do_reset();
    i_valid = 1; i_addr = ia; i_len = 0;
    // Data re-requests every idle, instruction always pending: every fifth grant is i.
    for (int k = 0; k < 10; k++) begin
      d_valid = 1; d_is_write = 0; d_addr = 64'h1000 + 64'(k); d_len = 0;
      exp_i = ((k % (MaxWait + 1)) == MaxWait);
      tick();
      c_ready = 1; c_last = 1;
      #2;
      n_total++;
      if (c_addr !== (exp_i ? ia : 64'h1000 + 64'(k)))
        $display("FAIL starve_grant%0d: got addr %h want %h", k, c_addr,
                 exp_i ? ia : 64'h1000 + 64'(k));
      else n_pass++;
      n_total++;
      if ({i_ready, d_ready} !== {exp_i, !exp_i})
        $display("FAIL starve_route%0d: got %b want %b", k, {i_ready, d_ready}, {exp_i, !exp_i});
      else n_pass++;
      tick();
      c_ready = 0; c_last = 0;
    end
    d_valid = 0; i_valid = 0;
  endtask

  task automatic test_burst();
    logic [63:0] rd;
    do_reset();
    i_valid = 1; i_addr = rand64(); i_len = 4'd3;
    tick();
    d_valid = 1; d_addr = rand64(); d_len = 0;
    for (int b = 0; b < 4; b++) begin
      c_ready = 1; c_last = (b == 3); rd = rand64(); c_rdata = rd;
      #2;
      n_total++;
      if ({c_valid, c_len, i_ready, i_last, d_ready, d_last} !== {1'b1, 4'd3, 1'b1, b == 3, 2'b00})
        $display("FAIL burst_beat%0d: got %b want %b", b,
                 {c_valid, c_len, i_ready, i_last, d_ready, d_last},
                 {1'b1, 4'd3, 1'b1, b == 3, 2'b00});
      else n_pass++;
      n_total++;
      if (i_rdata !== rd) $display("FAIL burst_rdata%0d: got %h want %h", b, i_rdata, rd);
      else n_pass++;
      tick();
    end
    i_valid = 0; c_ready = 0; c_last = 0;
    #2;
    n_total++;
    if ({c_valid, d_ready} !== 2'b00) $display("FAIL burst_gap: got %b want 00", {c_valid, d_ready});
    else n_pass++;
    d_valid = 0;
  endtask

  task automatic test_hold();
    logic [63:0] w;
    w = rand64();
    do_reset();
    d_valid = 1; d_is_write = 1; d_addr = 64'h100; d_strobe = 8'h3C; d_wdata = w; d_len = 4'h7;
    tick();
    // Requester scribbles on its fields mid-transaction; cbus must not move.
    d_addr = 64'h200; d_strobe = 8'hFF; d_wdata = ~w; d_len = 4'h2; d_is_write = 0;
    for (int c = 0; c < 4; c++) begin
      c_ready = (c == 3); c_last = (c == 3);
      #2;
      n_total++;
      if ({c_addr, c_len, c_strobe, c_wdata, c_is_write} !== {64'h100, 4'd0, 8'h3C, w, 1'b1})
        $display("FAIL hold_cyc%0d: got %h want %h", c,
                 {c_addr, c_len, c_strobe, c_wdata, c_is_write}, {64'h100, 4'd0, 8'h3C, w, 1'b1});
      else n_pass++;
      n_total++;
      if ({d_ready, d_last} !== {c == 3, c == 3})
        $display("FAIL hold_ready%0d: got %b want %b", c, {d_ready, d_last}, {c == 3, c == 3});
      else n_pass++;
      tick();
    end
    d_valid = 0; c_ready = 0; c_last = 0;
  endtask

  task automatic test_reset_busy();
    do_reset();
    i_valid = 1; i_addr = rand64(); i_len = 0;
    // Four data wins with i pending saturate the starvation count.
    for (int k = 0; k < 4; k++) begin
      d_valid = 1; d_is_write = 0; d_addr = 64'h2000 + 64'(k); d_len = 0;
      tick();
      if (k < 3) begin
        c_ready = 1; c_last = 1;
        tick();
        c_ready = 0; c_last = 0;
      end
    end
    #2;
    n_total++;
    if ({c_valid, c_addr} !== {1'b1, 64'h2003})
      $display("FAIL rstbusy_pre: got %h want %h", {c_valid, c_addr}, {1'b1, 64'h2003});
    else n_pass++;
    reset = 1;
    tick();
    reset = 0; c_ready = 1; c_last = 1;
    #2;
    n_total++;
    if ({c_valid, d_ready, d_last, i_ready, i_last} !== 5'b0)
      $display("FAIL rstbusy_abort: got %b want 00000", {c_valid, d_ready, d_last, i_ready, i_last});
    else n_pass++;
    tick();
    c_ready = 0; c_last = 0;
    #2;
    // Starvation count was cleared, so data wins again.
    n_total++;
    if ({c_valid, c_addr} !== {1'b1, 64'h2003})
      $display("FAIL rstbusy_regrant: got %h want %h", {c_valid, c_addr}, {1'b1, 64'h2003});
    else n_pass++;
    idle_inputs();
  endtask

  task automatic test_random();
    bit m_busy, m_owner, m_write, pick_i, d_pend, i_pend;
    bit exp_dr, exp_ir;
    logic [AddrW-1:0] m_addr;
    logic [StrbW-1:0] m_strobe;
    logic [DataW-1:0] m_wdata;
    int m_len, m_beat, m_losses;
    m_busy = 0; m_owner = 0; m_write = 0; m_addr = '0; m_strobe = '0; m_wdata = '0;
    m_len = 0; m_beat = 0; m_losses = 0; d_pend = 0; i_pend = 0;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!d_pend && $urandom_range(0, 3) != 0) begin
        d_pend = 1; d_is_write = 1'($urandom); d_addr = rand64(); d_strobe = 8'($urandom);
        d_wdata = rand64(); d_len = 4'($urandom_range(0, 3));
      end else if (d_pend && m_busy && !m_owner) begin
        d_is_write = 1'($urandom); d_addr = rand64(); d_strobe = 8'($urandom);
        d_wdata = rand64(); d_len = 4'($urandom);
      end
      if (!i_pend && $urandom_range(0, 1) != 0) begin
        i_pend = 1; i_addr = rand64(); i_len = 4'($urandom_range(0, 3));
      end else if (i_pend && m_busy && m_owner) begin
        i_addr = rand64(); i_len = 4'($urandom);
      end
      d_valid = d_pend;
      i_valid = i_pend;
      if (m_busy) begin
        c_ready = ($urandom_range(0, 2) != 0);
        c_last = c_ready && (m_beat == m_len);
      end else begin
        c_ready = 1'($urandom); c_last = 1'($urandom);
      end
      c_rdata = rand64();
      #2;
      n_total++;
      if (c_valid !== m_busy) $display("FAIL rnd_c_valid@%0d: got %b want %b", cyc, c_valid, m_busy);
      else n_pass++;
      if (m_busy) begin
        n_total++;
        if ({c_addr, c_is_write, c_strobe, c_wdata, c_len} !==
            {m_addr, m_write, m_strobe, m_wdata, 4'(m_len)})
          $display("FAIL rnd_req@%0d: got %h want %h", cyc,
                   {c_addr, c_is_write, c_strobe, c_wdata, c_len},
                   {m_addr, m_write, m_strobe, m_wdata, 4'(m_len)});
        else n_pass++;
      end
      exp_dr = m_busy && !m_owner && c_ready;
      exp_ir = m_busy && m_owner && c_ready;
      n_total++;
      if ({d_ready, d_last, i_ready, i_last} !== {exp_dr, exp_dr && c_last, exp_ir, exp_ir && c_last})
        $display("FAIL rnd_hs@%0d: got %b want %b", cyc, {d_ready, d_last, i_ready, i_last},
                 {exp_dr, exp_dr && c_last, exp_ir, exp_ir && c_last});
      else n_pass++;
      n_total++;
      if ({d_rdata, i_rdata} !== {(m_busy && !m_owner) ? c_rdata : 64'h0,
                                  (m_busy && m_owner) ? c_rdata : 64'h0})
        $display("FAIL rnd_rdata@%0d: got %h want routed %h", cyc, {d_rdata, i_rdata}, c_rdata);
      else n_pass++;
      // Transaction-level model update at the coming edge.
      if (m_busy) begin
        if (c_ready) begin
          if (c_last) begin
            m_busy = 0;
            if (m_owner) i_pend = 0;
            else d_pend = 0;
          end else begin
            m_beat++;
          end
        end
      end else if (d_pend || i_pend) begin
        pick_i = i_pend && (!d_pend || m_losses == MaxWait);
        if (pick_i) begin
          m_losses = 0; m_addr = i_addr; m_write = 0; m_strobe = '0; m_wdata = '0; m_len = i_len;
        end else begin
          if (i_pend && m_losses < MaxWait) m_losses++;
          m_addr = d_addr; m_write = d_is_write; m_strobe = d_strobe; m_wdata = d_wdata;
          m_len = d_is_write ? 0 : int'(d_len);
        end
        m_owner = pick_i; m_busy = 1; m_beat = 0;
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    tick();
    test_reset();
    test_single_read();
    test_priority();
    test_starvation();
    test_burst();
    test_hold();
    test_reset_busy();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Shares one memory bus (cbus) between the core's data port (d_*) and instruction port (i_*), sitting between the pipeline's fetch/memory stages and the memory/cache interface. Data has fixed priority; a starvation counter forces an instruction grant after MAX_WAIT consecutive losses. Each granted request is latched and held stable on cbus until the final beat completes.

Parameters:
ADDR_W, 64, address width of all ports
DATA_W, 64, beat data width; strobe width is DATA_W/8
MAX_WAIT, 4, consecutive lost arbitrations after which a pending instruction request wins; range 1..15

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
d_valid  input  1  data request pending; held until final d_ready&&d_last
d_is_write  input  1  1 = write, 0 = read
d_addr  input  ADDR_W  data request address
d_strobe  input  DATA_W/8  byte-enable mask for writes
d_wdata  input  DATA_W  write data
d_len  input  4  read burst beats minus 1; writes are single-beat
d_ready  output  1  beat accepted/returned for data port
d_last  output  1  final beat for data port
d_rdata  output  DATA_W  read data for data port
i_valid  input  1  instruction read request pending
i_addr  input  ADDR_W  instruction fetch address
i_len  input  4  burst beats minus 1
i_ready  output  1  beat returned for instruction port
i_last  output  1  final beat for instruction port
i_rdata  output  DATA_W  read data for instruction port
c_valid  output  1  cbus request valid
c_is_write  output  1  cbus write
c_addr  output  ADDR_W  cbus address
c_strobe  output  DATA_W/8  cbus byte enables
c_wdata  output  DATA_W  cbus write data
c_len  output  4  cbus burst length minus 1
c_ready  input  1  cbus beat handshake
c_last  input  1  cbus final beat
c_rdata  input  DATA_W  cbus read data

Behaviour:
- States IDLE, BUSY. Reset: IDLE, grant none, wait_cnt 0, all c_* registers 0, d_/i_ ready/last/rdata 0.
- IDLE, any valid: pick i if i_valid && (!d_valid || wait_cnt==MAX_WAIT), else d. Latch chosen fields into request register (i: is_write 0, strobe 0, wdata 0; d write: c_len forced 0); go BUSY. c_valid=1 from the next cycle (1-cycle grant latency).
- wait_cnt: +1 (saturating at MAX_WAIT) when d is granted while i_valid=1; cleared when i is granted; otherwise unchanged.
- BUSY: c_* driven only from the latched register; changes on d_*/i_* inputs are ignored. Granted port sees ready=c_ready, last=c_ready&&c_last, rdata=c_rdata in the same cycle (combinational); the other port sees ready/last/rdata all 0.
- BUSY, c_ready&&c_last: go IDLE; c_valid=0 next cycle. Minimum one c_valid-low cycle between transactions. Requesters drop valid the cycle after their final ready&&last; any valid seen in IDLE is a new request.
- c_ready/c_last/c_rdata ignored in IDLE; ready/last outputs 0 there.
- Reset during BUSY: abort; next cycle IDLE, c_valid=0, wait_cnt 0; the lost transaction is not replayed.

Test Plan:
- d read, d_addr=0x80000000, d_len=0, at cycle 0 -> cycle 1 c_valid=1, c_addr=0x80000000; c_ready=c_last=1, c_rdata=0x1122334455667788 in cycle 3 -> same cycle d_ready=d_last=1, d_rdata=0x1122334455667788; cycle 4 c_valid=0.
- d and i valid together, wait_cnt=0 -> d granted, wait_cnt=1; i granted at the IDLE after d's last; i_ready stays 0 during d.
- MAX_WAIT=4, d re-requests every IDLE, i held valid -> 4 d grants, 5th grant i, wait_cnt returns to 0.
- i burst i_len=3, c_ready every cycle, c_last on 4th beat -> i_ready high 4 cycles, i_last only on 4th, d_ready 0 throughout.
- d write granted, then d_addr changes 0x100 -> 0x200 mid-BUSY -> c_addr stays 0x100, c_len=0, c_strobe stable until last.
- reset pulsed in BUSY -> next cycle c_valid=0, outputs 0; d_valid held -> fresh grant, c_valid=1 one cycle after reset deasserts.
